hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline interlock controller for the decode stage. It compares the register operands of the instruction in decode against the instruction in execute, and sequences stalls for load-use hazards and multi-cycle multiplies. It also flushes wrong-path instructions after a taken branch or jump. It drives the PC, IF/ID and ID/EX register enables and flushes around the decode stage.

Parameters:
MUL_LAT, 4, number of cycles a multiply occupies EX (>=1)
BR_FLUSH, 1, number of cycles IfIdFlush/IdExBubble are held after a taken branch/jump (>=1)

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
IdRsAddr  input  5  rs field of instruction in decode
IdRtAddr  input  5  rt field of instruction in decode
IdUsesRs  input  1  decode instruction reads rs
IdUsesRt  input  1  decode instruction reads rt
IdMULOp  input  1  decode instruction is a multiply
ExMemRead  input  1  instruction in EX is a load
ExRAddr  input  5  destination register of instruction in EX
BranchTaken  input  1  branch/jump resolved taken in EX this cycle
PCWrite  output  1  PC load enable
IfIdWrite  output  1  IF/ID register enable
IfIdFlush  output  1  IF/ID register clears to NOP
IdExBubble  output  1  ID/EX register loads NOP (all controls 0)
MulBusy  output  1  multiply in progress
State  output  2  current FSM state (debug)

Behaviour:
- Clock and reset: one clock, Clock. Reset nReset is asynchronous, active-low.
- Reset: State=RUN(2'd0), counter=0. While nReset=0, outputs are forced to PCWrite=0, IfIdWrite=0, IfIdFlush=1, IdExBubble=1, MulBusy=0.
- Outputs are combinational from registered state plus current inputs. State and counter update on the rising edge of Clock.
- Counter width is clog2(max(MUL_LAT,BR_FLUSH)+1).
- States: RUN=0, MUL_BUSY=1, FLUSH=2. Encoding 3 is illegal and returns to RUN on the next edge.
- Load-use hazard (lu), all of the following:
  - ExMemRead=1
  - ExRAddr!=0
  - (IdUsesRs and IdRsAddr==ExRAddr) or (IdUsesRt and IdRtAddr==ExRAddr)
- Register 0 never causes a hazard.
- RUN, priority order (BranchTaken > lu > MUL issue):
  - BranchTaken=1: PCWrite=1, IfIdWrite=1, IfIdFlush=1, IdExBubble=1. If BR_FLUSH>1, go to FLUSH with counter=BR_FLUSH-2; otherwise stay in RUN. lu and IdMULOp are ignored that cycle.
  - Else lu=1: PCWrite=0, IfIdWrite=0, IdExBubble=1, IfIdFlush=0. Stay in RUN. The stall lasts exactly 1 cycle, since the load leaves EX.
  - Else IdMULOp=1: normal advance (PCWrite=1, IfIdWrite=1, others 0). The multiply enters EX. If MUL_LAT>1, go to MUL_BUSY with counter=MUL_LAT-2; otherwise stay in RUN.
  - Else: PCWrite=1, IfIdWrite=1, IfIdFlush=0, IdExBubble=0.
- MUL_BUSY:
  - Outputs: PCWrite=0, IfIdWrite=0, IdExBubble=1, IfIdFlush=0, MulBusy=1.
  - lu and IdMULOp are ignored.
  - counter==0: go to RUN next edge. Otherwise decrement.
  - Total stall is MUL_LAT-1 cycles after the issue cycle.
  - BranchTaken is ignored; EX holds a multiply, so BranchTaken cannot legally be asserted here.
- FLUSH:
  - Outputs: PCWrite=1, IfIdWrite=1, IfIdFlush=1, IdExBubble=1, MulBusy=0.
  - counter==0: go to RUN. Otherwise decrement.
  - BranchTaken is ignored (EX holds a bubble).
- MulBusy=1 only in MUL_BUSY.
- Reset asserted mid-MUL_BUSY or mid-FLUSH aborts immediately to reset outputs; RUN is entered on the first edge after release.

Test Plan:
1. Load-use: ExMemRead=1, ExRAddr=5, IdUsesRs=1, IdRsAddr=5 -> one cycle PCWrite=0, IfIdWrite=0, IdExBubble=1. Same stimulus with ExRAddr=0, or with IdUsesRs=0 -> no stall.
2. Multiply, MUL_LAT=4: IdMULOp=1 for one cycle in RUN -> issue cycle normal, then MulBusy=1 and PCWrite=0 for 3 cycles, State=1, then RUN.
3. Taken branch, BR_FLUSH=1: BranchTaken=1 -> IfIdFlush=1, IdExBubble=1, PCWrite=1 for one cycle, State stays 0. With BR_FLUSH=3 -> flush signals held for 3 cycles, State=2 for the last 2.
4. Priority: BranchTaken=1 with lu=1 and IdMULOp=1 in the same cycle -> branch behaviour only, no MUL_BUSY entry.
5. Reset mid-op: drop nReset in cycle 2 of MUL_BUSY -> outputs immediately PCWrite=0, IfIdFlush=1, IdExBubble=1, MulBusy=0. After release -> State=0 with normal advance.
6. MUL_LAT=1: IdMULOp=1 -> no stall, MulBusy never asserted, State stays 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage pipeline interlock controller
// Inputs : Clock, nReset (async, active-low), IdRsAddr/IdRtAddr/IdUsesRs/IdUsesRt/IdMULOp
//          (decode operands), ExMemRead/ExRAddr (instruction in EX), BranchTaken
// Outputs: PCWrite, IfIdWrite, IfIdFlush, IdExBubble, MulBusy, State (debug)
module hazard_ctrl #(
  parameter int MUL_LAT  = 4,
  parameter int BR_FLUSH = 1
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [4:0] IdRsAddr,
  input  logic [4:0] IdRtAddr,
  input  logic       IdUsesRs,
  input  logic       IdUsesRt,
  input  logic       IdMULOp,
  input  logic       ExMemRead,
  input  logic [4:0] ExRAddr,
  input  logic       BranchTaken,
  output logic       PCWrite,
  output logic       IfIdWrite,
  output logic       IfIdFlush,
  output logic       IdExBubble,
  output logic       MulBusy,
  output logic [1:0] State
);

  localparam int MAX_CNT = (MUL_LAT > BR_FLUSH) ? MUL_LAT : BR_FLUSH;
  localparam int CW      = $clog2(MAX_CNT + 1);
  // Counter holds "remaining cycles after this one", hence the -2 preload.
  localparam logic [CW-1:0] MUL_INIT = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0] BR_INIT  = CW'((BR_FLUSH > 1) ? BR_FLUSH - 2 : 0);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lu;
  logic          pc_wr, ifid_wr, ifid_fl, idex_bub, mul_bsy;

  // Register 0 is hardwired, so a load targeting it never interlocks.
  assign lu = ExMemRead && (ExRAddr != 5'd0) &&
              ((IdUsesRs && (IdRsAddr == ExRAddr)) ||
               (IdUsesRt && (IdRtAddr == ExRAddr)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_wr    = 1'b1;
    ifid_wr  = 1'b1;
    ifid_fl  = 1'b0;
    idex_bub = 1'b0;
    mul_bsy  = 1'b0;
    case (state_q)
      RUN: begin
        if (BranchTaken) begin
          ifid_fl  = 1'b1;
          idex_bub = 1'b1;
          if (BR_FLUSH > 1) begin
            state_d = FLUSH;
            cnt_d   = BR_INIT;
          end
        end else if (lu) begin
          // Single-cycle stall: the load leaves EX on this edge.
          pc_wr    = 1'b0;
          ifid_wr  = 1'b0;
          idex_bub = 1'b1;
        end else if (IdMULOp) begin
          if (MUL_LAT > 1) begin
            state_d = MUL_BUSY;
            cnt_d   = MUL_INIT;
          end
        end
      end
      MUL_BUSY: begin
        pc_wr    = 1'b0;
        ifid_wr  = 1'b0;
        idex_bub = 1'b1;
        mul_bsy  = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FLUSH: begin
        ifid_fl  = 1'b1;
        idex_bub = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces a frozen, fully-bubbled pipeline regardless of state.
  assign PCWrite    = nReset ? pc_wr    : 1'b0;
  assign IfIdWrite  = nReset ? ifid_wr  : 1'b0;
  assign IfIdFlush  = nReset ? ifid_fl  : 1'b1;
  assign IdExBubble = nReset ? idex_bub : 1'b1;
  assign MulBusy    = nReset ? mul_bsy  : 1'b0;
  assign State      = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       Clock = 1'b0;
  logic       nReset;
  logic [4:0] IdRsAddr, IdRtAddr, ExRAddr;
  logic       IdUsesRs, IdUsesRt, IdMULOp, ExMemRead, BranchTaken;

  logic       pc0, w0, fl0, bu0, mb0, pc1, w1, fl1, bu1, mb1;
  logic [1:0] st0, st1;
  logic [6:0] o0, o1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  hazard_ctrl #(.MUL_LAT(4), .BR_FLUSH(1)) dut0 (
    .Clock(Clock), .nReset(nReset), .IdRsAddr(IdRsAddr), .IdRtAddr(IdRtAddr),
    .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt), .IdMULOp(IdMULOp),
    .ExMemRead(ExMemRead), .ExRAddr(ExRAddr), .BranchTaken(BranchTaken),
    .PCWrite(pc0), .IfIdWrite(w0), .IfIdFlush(fl0), .IdExBubble(bu0),
    .MulBusy(mb0), .State(st0));

  hazard_ctrl #(.MUL_LAT(1), .BR_FLUSH(3)) dut1 (
    .Clock(Clock), .nReset(nReset), .IdRsAddr(IdRsAddr), .IdRtAddr(IdRtAddr),
    .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt), .IdMULOp(IdMULOp),
    .ExMemRead(ExMemRead), .ExRAddr(ExRAddr), .BranchTaken(BranchTaken),
    .PCWrite(pc1), .IfIdWrite(w1), .IfIdFlush(fl1), .IdExBubble(bu1),
    .MulBusy(mb1), .State(st1));

  // Output vector: {PCWrite, IfIdWrite, IfIdFlush, IdExBubble, MulBusy, State}
  assign o0 = {pc0, w0, fl0, bu0, mb0, st0};
  assign o1 = {pc1, w1, fl1, bu1, mb1, st1};

  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001000;
  localparam logic [6:0] BRPAT = 7'b1111000;
  localparam logic [6:0] MULST = 7'b0001101;
  localparam logic [6:0] FLST  = 7'b1111010;
  localparam logic [6:0] RSTO  = 7'b0011000;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ra;
    logic       urs, urt, mul, mr, br;
    logic [6:0] exp;
  } vec_t;

  // Behavioural model: remaining stall / flush cycles per instance.
  int mul_lat[2]  = '{4, 1};
  int br_flush[2] = '{1, 3};
  int busy_left[2];
  int flush_left[2];

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  function automatic bit lu_f();
    return ExMemRead && (ExRAddr != 0) &&
           ((IdUsesRs && IdRsAddr == ExRAddr) || (IdUsesRt && IdRtAddr == ExRAddr));
  endfunction

  function automatic logic [6:0] model_out(input int k);
    if (busy_left[k] > 0)  return MULST;
    if (flush_left[k] > 0) return FLST;
    if (BranchTaken)       return BRPAT;
    if (lu_f())            return STALL;
    return NORM;
  endfunction

  task automatic model_adv(input int k);
    if (busy_left[k] > 0)       busy_left[k]--;
    else if (flush_left[k] > 0) flush_left[k]--;
    else if (BranchTaken)       flush_left[k] = br_flush[k] - 1;
    else if (lu_f())            ;
    else if (IdMULOp)           busy_left[k] = mul_lat[k] - 1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mul, input logic mr,
                        input logic [4:0] ra, input logic br);
    IdRsAddr = rs; IdRtAddr = rt; IdUsesRs = urs; IdUsesRt = urt;
    IdMULOp = mul; ExMemRead = mr; ExRAddr = ra; BranchTaken = br;
  endtask

  task automatic idle_cycle();
    @(posedge Clock); #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    @(posedge Clock); #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    nReset = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    for (int k = 0; k < 2; k++) begin busy_left[k] = 0; flush_left[k] = 0; end
  endtask

  vec_t tbl[$];

  initial begin
    nReset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_d0", o0, RSTO);
    chk("reset_d1", o1, RSTO);
    do_reset();

    // Single-cycle decode vectors from RUN; inputs return to idle before the edge.
    tbl.push_back('{"lu_rs",       5'd5, 5'd0, 5'd5, 1, 0, 0, 1, 0, STALL});
    tbl.push_back('{"lu_r0",       5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 0, NORM});
    tbl.push_back('{"lu_nors",     5'd5, 5'd0, 5'd5, 0, 0, 0, 1, 0, NORM});
    tbl.push_back('{"lu_rt",       5'd1, 5'd7, 5'd7, 0, 1, 0, 1, 0, STALL});
    tbl.push_back('{"lu_nort",     5'd1, 5'd7, 5'd7, 1, 0, 0, 1, 0, NORM});
    tbl.push_back('{"no_load",     5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, NORM});
    tbl.push_back('{"mul_issue",   5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, NORM});
    tbl.push_back('{"branch",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, BRPAT});
    tbl.push_back('{"br_over_lu",  5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 1, BRPAT});
    tbl.push_back('{"lu_over_mul", 5'd3, 5'd0, 5'd3, 1, 0, 1, 1, 0, STALL});
    foreach (tbl[i]) begin
      @(posedge Clock); #1;
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].mul,
             tbl[i].mr, tbl[i].ra, tbl[i].br);
      @(negedge Clock);
      chk({tbl[i].name, "_d0"}, o0, tbl[i].exp);
      chk({tbl[i].name, "_d1"}, o1, tbl[i].exp);
      #1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Multiply: d0 stalls three cycles, d1 never stalls.
    @(posedge Clock); #1;
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge Clock);
    chk("mul_iss_d0", o0, NORM);
    chk("mul_iss_d1", o1, NORM);
    for (int c = 0; c < 3; c++) begin
      idle_cycle();
      chk("mul_busy_d0", o0, MULST);
      chk("mul_busy_d1", o1, NORM);
    end
    idle_cycle();
    chk("mul_done_d0", o0, NORM);

    // Branch with lu and multiply pending: branch wins, d1 holds flush two more cycles.
    @(posedge Clock); #1;
    set_in(5'd5, 0, 1, 0, 1, 1, 5'd5, 1);
    @(negedge Clock);
    chk("prio_d0", o0, BRPAT);
    chk("prio_d1", o1, BRPAT);
    for (int c = 0; c < 2; c++) begin
      idle_cycle();
      chk("prio_after_d0", o0, NORM);
      chk("flush_d1", o1, FLST);
    end
    idle_cycle();
    chk("flush_done_d1", o1, NORM);

    // Reset in the second MUL_BUSY cycle aborts at once.
    @(posedge Clock); #1;
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    idle_cycle();
    chk("pre_rst_d0", o0, MULST);
    @(posedge Clock); #1;
    nReset = 1'b0;
    #1;
    chk("mid_rst_d0", o0, RSTO);
    @(negedge Clock);
    nReset = 1'b1;
    #1;
    chk("rst_rel_d0", o0, NORM);
    idle_cycle();
    chk("post_rst_d0", o0, NORM);

    // Random stimulus against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge Clock); #1;
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
             1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      @(negedge Clock);
      chk("rand_d0", o0, model_out(0));
      chk("rand_d1", o1, model_out(1));
      model_adv(0);
      model_adv(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
